ej32_dstack: RTL
================

EJ32_DSTACK -- requirements
Module: ej32_dstack

Interface
REQ-001 SHALL have parameter DSZ, default 32, data width in bits.
REQ-002 SHALL have parameter DEPTH, default 64, total stack capacity in entries including TOS and NOS; legal range 4..1024.
REQ-003 SHALL have parameter CW, default $clog2(DEPTH+1), element-count width.
REQ-004 clk  in  1  sole clock; all state changes on its rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 en  in  1  operation enable; when 0, the stack holds all state.
REQ-007 op  in  3  stack opcode: 0 NOP, 1 PUSH, 2 POP, 3 ALU, 4 SWAP, 5 DUP, 6 OVER, 7 REPL.
REQ-008 v  in  DSZ  operand value for PUSH, ALU and REPL.
REQ-009 err_clr  in  1  clears the sticky error flags.
REQ-010 t_o  out  DSZ  top of stack (TOS) register.
REQ-011 s_o  out  DSZ  next on stack (NOS) register.
REQ-012 depth_o  out  CW  current element count.
REQ-013 full_o, empty_o  out  1 each  depth_o==DEPTH and depth_o==0 respectively; both combinational from the count.
REQ-014 err_o  out  2  sticky error flags: bit0 overflow, bit1 underflow.

Function
REQ-015 Storage SHALL be TOS register t, NOS register s, and a register array mem[0..DEPTH-3] holding deeper entries; with n = depth_o, the third element is mem[n-3]; mem is read combinationally.
REQ-016 Every op SHALL complete in one cycle when en=1; results SHALL be visible on t_o, s_o and depth_o on the next rising edge.
REQ-017 PUSH SHALL do: mem[n-2]<=s (only if n>=2), s<=t, t<=v, n<=n+1.
REQ-018 DUP SHALL act as PUSH with value t; OVER SHALL act as PUSH with value s.
REQ-019 POP SHALL do: t<=s, s<=mem[n-3] (0 if n<3), n<=n-1.
REQ-020 ALU SHALL do: t<=v, s<=mem[n-3] (0 if n<3), n<=n-1 (binary-operator result replaces the T/S pair).
REQ-021 SWAP SHALL exchange t and s, leaving n unchanged.
REQ-022 REPL SHALL do t<=v, leaving s and n unchanged; NOP SHALL change nothing.
REQ-023 Legality SHALL be: PUSH, DUP and OVER need n<DEPTH; DUP and REPL need n>=1; POP needs n>=1; OVER, ALU and SWAP need n>=2.
REQ-024 Slots vacated by a POP or ALU that leave n<2 SHALL read back as 0 on s_o; when n==0, t_o SHALL be 0.
REQ-025 err_clr SHALL act regardless of en; if err_clr and a new error occur in the same cycle, the new error flag SHALL be set.

Reset
REQ-026 rst low SHALL immediately force t_o=0, s_o=0, depth_o=0, err_o=0, empty_o=1 and full_o=0, including in the middle of an operation sequence.
REQ-027 mem contents SHALL NOT be reset; they are unobservable until written.
REQ-028 First op SHALL be accepted on the first rising edge after rst deasserts.

Configuration
REQ-029 Macro EJ32_DSTACK_CHK_EN SHALL select the checking behaviour at compile time.
REQ-030 With EJ32_DSTACK_CHK_EN defined, an illegal op (per REQ-023) SHALL leave t, s, mem and n unchanged and SHALL set err_o[0] for overflow or err_o[1] for underflow.
REQ-031 Without EJ32_DSTACK_CHK_EN, every op SHALL execute unconditionally, n SHALL wrap modulo 2^CW, err_o SHALL be tied to 0, and err_clr SHALL be ignored.

Verification
REQ-032 Scenario: reset, then PUSH 1, 2, 3 -> t_o=3, s_o=2, depth_o=3, empty_o=0.
REQ-033 Scenario: with DEPTH=4 and CHK_EN, PUSH 1..4 then PUSH 9 -> full_o=1, err_o=01, t_o=4, s_o=3, depth_o=4.
REQ-034 Scenario: with CHK_EN on an empty stack, POP -> err_o=10, depth_o=0; then err_clr=1 -> err_o=00.
REQ-035 Scenario: PUSH 5, PUSH 7, OVER -> t_o=5, s_o=7, depth_o=3; then SWAP -> t_o=7, s_o=5.
REQ-036 Scenario: PUSH 5, PUSH 7, ALU with v=12 -> t_o=12, s_o=0, depth_o=1; then POP -> empty_o=1, t_o=0.
REQ-037 Scenario: PUSH 1, 2, 3, then pull rst low between edges -> all outputs return to reset values without waiting for a clock edge; en=0 with op=PUSH afterwards -> no change.

Source files
------------

// File: rtl/ej32_dstack.sv
// ej32_dstack: data stack with TOS/NOS held in registers and deeper entries in a
// register array. Every op completes in one cycle when en is high.
// Compile-time option: define EJ32_DSTACK_CHK_EN to block illegal ops and raise
// sticky overflow/underflow flags; otherwise every op executes unconditionally.
module ej32_dstack #(
   parameter int unsigned DSZ   = 32,
   parameter int unsigned DEPTH = 64,
   parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           en,
   input  logic [2:0]     op,
   input  logic [DSZ-1:0] v,
   input  logic           err_clr,
   output logic [DSZ-1:0] t_o,
   output logic [DSZ-1:0] s_o,
   output logic [CW-1:0]  depth_o,
   output logic           full_o,
   output logic           empty_o,
   output logic [1:0]     err_o
);

   localparam int unsigned MD = DEPTH - 2;       // entries below NOS
   localparam int unsigned MW = $clog2(MD);
   localparam logic [CW-1:0] DepthN = CW'(DEPTH);

   typedef enum logic [2:0] {
      OpNop  = 3'd0,
      OpPush = 3'd1,
      OpPop  = 3'd2,
      OpAlu  = 3'd3,
      OpSwap = 3'd4,
      OpDup  = 3'd5,
      OpOver = 3'd6,
      OpRepl = 3'd7
   } op_e;

   logic [DSZ-1:0] t_q, t_d;
   logic [DSZ-1:0] s_q, s_d;
   logic [CW-1:0]  n_q, n_d;
   logic [DSZ-1:0] mem [MD];

   logic [DSZ-1:0] third;
   logic [MW-1:0]  rd_idx;
   logic [MW-1:0]  wr_idx;
   logic           wr_en;
   logic [DSZ-1:0] push_val;
   logic           ovf;
   logic           udf;
   logic           illegal;

   // Third element, mem[n-3]; zero when it does not exist or n is out of range
   always_comb begin
      third  = '0;
      rd_idx = MW'(n_q - CW'(3));
      if (n_q >= CW'(3) && n_q <= DepthN) begin
         third = mem[rd_idx];
      end
   end

   // Legality classification of the requested op
   always_comb begin
      ovf      = 1'b0;
      udf      = 1'b0;
      push_val = v;
      case (op_e'(op))
         OpPush: ovf = (n_q >= DepthN);
         OpDup: begin
            ovf      = (n_q >= DepthN);
            udf      = (n_q == '0);
            push_val = t_q;
         end
         OpOver: begin
            ovf      = (n_q >= DepthN);
            udf      = (n_q < CW'(2));
            push_val = s_q;
         end
         OpPop:  udf = (n_q == '0);
         OpRepl: udf = (n_q == '0);
         OpAlu:  udf = (n_q < CW'(2));
         OpSwap: udf = (n_q < CW'(2));
         default: ;
      endcase
   end

`ifdef EJ32_DSTACK_CHK_EN
   logic [1:0] err_q, err_d;

   assign illegal = ovf | udf;

   // Sticky error flags; a new error wins over a same-cycle clear
   always_comb begin
      err_d = err_clr ? 2'b00 : err_q;
      if (en) begin
         if (ovf) begin
            err_d[0] = 1'b1;
         end else if (udf) begin
            err_d[1] = 1'b1;
         end
      end
   end

   // Error flag register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         err_q <= 2'b00;
      end else begin
         err_q <= err_d;
      end
   end

   assign err_o = err_q;
`else
   logic unused_chk;

   assign illegal    = 1'b0;
   assign unused_chk = ovf | udf | err_clr;
   assign err_o      = 2'b00;
`endif

   // Next-state for TOS, NOS, count and the spill write into mem
   always_comb begin
      t_d    = t_q;
      s_d    = s_q;
      n_d    = n_q;
      wr_en  = 1'b0;
      wr_idx = MW'(n_q - CW'(2));
      if (en && !illegal) begin
         case (op_e'(op))
            OpPush, OpDup, OpOver: begin
               t_d   = push_val;
               s_d   = t_q;
               n_d   = n_q + CW'(1);
               // NOS spills into mem only when it holds a real element
               wr_en = (n_q >= CW'(2)) && (n_q < DepthN);
            end
            OpPop: begin
               t_d = (n_q <= CW'(1)) ? '0 : s_q;
               s_d = third;
               n_d = n_q - CW'(1);
            end
            OpAlu: begin
               t_d = v;
               s_d = third;
               n_d = n_q - CW'(1);
            end
            OpSwap: begin
               t_d = s_q;
               s_d = t_q;
            end
            OpRepl: t_d = v;
            default: ;
         endcase
      end
   end

   // TOS/NOS/count registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         t_q <= '0;
         s_q <= '0;
         n_q <= '0;
      end else begin
         t_q <= t_d;
         s_q <= s_d;
         n_q <= n_d;
      end
   end

   // Deeper entries; intentionally not reset
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_idx] <= s_q;
      end
   end

   assign t_o     = t_q;
   assign s_o     = s_q;
   assign depth_o = n_q;
   assign full_o  = (n_q == DepthN);
   assign empty_o = (n_q == '0);

endmodule
